nvram_ioctl_bridge: RTL and testbench
=====================================

Name: nvram_ioctl_bridge

Overview:
- Host-side port of the 256-byte NVRAM shadow array: streams it to the MiSTer HPS on upload (save) and loads it from the HPS on download (restore).
- The store/recall engine copies between the game-visible X2212 array and the shadow array; this bridge is the other end, reading and writing that shadow array through its second port.
- Sits between hps_io ioctl signals and the nvram shadow port. Also produces a dirty flag for OSD autosave.

Parameters:
NV_INDEX, 8'd4, ioctl_index value that selects the NVRAM file
AW, 8, shadow address width (256 bytes)

Ports:
clk  in  1  system clock
reset_n  in  1  synchronous active-low reset
ioctl_index  in  8  file index from hps_io
ioctl_download  in  1  HPS→core transfer active
ioctl_upload  in  1  core→HPS transfer active
ioctl_wr  in  1  download byte strobe, 1 cycle
ioctl_rd  in  1  upload byte request strobe, 1 cycle
ioctl_addr  in  16  byte address of current transfer
ioctl_dout  in  8  download data
ioctl_din  out  8  upload data to HPS
ioctl_wait  out  1  stall request to hps_io
nv_busy  in  1  store/recall copy in progress in nvram
store_done  in  1  1-cycle pulse: shadow array updated by a STORE
sh_sel  out  1  bridge owns shadow port (nvram muxes on this)
sh_addr  out  AW  shadow address
sh_we  out  1  shadow write enable
sh_din  out  8  shadow write data
sh_dout  in  8  shadow read data, valid 1 cycle after sh_addr
nv_dirty  out  1  shadow changed since last save/load

Behaviour:
- All outputs registered. On reset (reset_n=0 at a clk edge): state IDLE, ioctl_wait=0, ioctl_din=8'h00, sh_sel=0, sh_we=0, sh_addr=0, sh_din=0, nv_dirty=0. Any transfer in progress is dropped; no partial write is issued afterwards.
- Active download: ioctl_download & (ioctl_index==NV_INDEX). Active upload: same with ioctl_upload. Other indices are ignored entirely.
- States: IDLE, DL_STALL, DL_WRITE, UL_STALL, UL_ADDR, UL_DATA.
- IDLE, ioctl_wr during active download, ioctl_addr<256:
  - Latch addr[7:0] and ioctl_dout.
  - If nv_busy: go to DL_STALL and raise ioctl_wait next cycle.
  - Else: go to DL_WRITE.
- IDLE, ioctl_wr with ioctl_addr>=256: ignored, no stall.
- DL_STALL: hold ioctl_wait=1 until nv_busy=0, then go to DL_WRITE.
- DL_WRITE: one cycle with sh_sel=1, sh_we=1, latched addr/data. Then go to IDLE and drop ioctl_wait in the same edge.
- Write latency: sh_we is high on the cycle after ioctl_wr when not busy.
- IDLE, ioctl_rd during active upload:
  - Latch addr, raise ioctl_wait next cycle.
  - If nv_busy: go to UL_STALL.
  - Else: go to UL_ADDR.
- UL_STALL: wait for nv_busy=0, then go to UL_ADDR.
- UL_ADDR: sh_sel=1, sh_addr driven. Go to UL_DATA.
- UL_DATA: sample sh_dout into ioctl_din, drop ioctl_wait, go to IDLE.
- Read latency without busy: ioctl_din is valid and ioctl_wait low 3 cycles after ioctl_rd. ioctl_wait is high for exactly 2 cycles.
- Upload with addr>=256: ioctl_din=8'hFF one cycle after ioctl_rd, no stall, shadow not accessed.
- sh_sel is high only in DL_WRITE, UL_ADDR, UL_DATA. The bridge never touches the shadow port while nv_busy=1.
- Strobes arriving while not IDLE are ignored; hps_io honours ioctl_wait.
- Transfer abort: if active download/upload deasserts in a STALL state, return to IDLE, ioctl_wait=0, and issue no write.
- nv_dirty:
  - Set by store_done.
  - Cleared on the falling edge of active upload.
  - Cleared on the falling edge of active download.
  - store_done coincident with a clear: set wins (nv_dirty=1).
- Writes during download do not set nv_dirty.

Test Plan:
- Download 256 bytes (data=addr^8'h5A), nv_busy=0 → sh_we pulses 256 times, each 1 cycle after ioctl_wr, correct addr/data, ioctl_wait never asserted; nv_dirty=0 after end.
- Download byte addr 8'h10 data 8'hC3 while nv_busy=1 for 20 cycles → ioctl_wait high from next cycle until nv_busy falls; sh_we exactly once after busy drops, at 8'h10 with 8'hC3.
- Upload with shadow preloaded (mem[i]=~i), ioctl_rd at addr 8'h3C → ioctl_wait high 2 cycles, ioctl_din=8'hC3 at cycle 3; ioctl_addr 16'h0100 → ioctl_din=8'hFF, no sh_sel.
- store_done pulse → nv_dirty=1; full upload then ioctl_upload falls → nv_dirty=0; store_done on the same cycle as that falling edge → nv_dirty stays 1.
- Mid-stall abort: ioctl_wr under nv_busy, then ioctl_download drops → IDLE, ioctl_wait=0, no sh_we ever; reset_n=0 during UL_ADDR → all outputs at reset values next edge.
- ioctl_index=8'd0 download/upload traffic → no sh_sel, sh_we, or ioctl_wait activity; ioctl_din unchanged.

Source files
------------

// File: rtl/nvram_ioctl_bridge.sv
// nvram_ioctl_bridge: streams the 256-byte NVRAM shadow array to/from the HPS over ioctl, with a dirty flag for autosave.
module nvram_ioctl_bridge #(
  parameter logic [7:0] NV_INDEX = 8'd4,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [7:0]    ioctl_index,
  input  logic          ioctl_download,
  input  logic          ioctl_upload,
  input  logic          ioctl_wr,
  input  logic          ioctl_rd,
  input  logic [15:0]   ioctl_addr,
  input  logic [7:0]    ioctl_dout,
  output logic [7:0]    ioctl_din,
  output logic          ioctl_wait,
  input  logic          nv_busy,
  input  logic          store_done,
  output logic          sh_sel,
  output logic [AW-1:0] sh_addr,
  output logic          sh_we,
  output logic [7:0]    sh_din,
  input  logic [7:0]    sh_dout,
  output logic          nv_dirty
);
  typedef enum logic [2:0] {IDLE, DL_STALL, DL_WRITE, UL_STALL, UL_ADDR, UL_DATA} state_t;
  state_t state, next;
  logic dl_act, ul_act, dl_q, ul_q, in_range, dl_go, ul_go, ul_oob;
  logic wait_n, sel_n, we_n;
  assign dl_act   = ioctl_download && ioctl_index == NV_INDEX;
  assign ul_act   = ioctl_upload && ioctl_index == NV_INDEX;
  assign in_range = ioctl_addr[15:AW] == '0;
  assign dl_go    = state == IDLE && ioctl_wr && dl_act && in_range;
  assign ul_go    = state == IDLE && ioctl_rd && ul_act && in_range && !dl_go;
  assign ul_oob   = state == IDLE && ioctl_rd && ul_act && !in_range && !dl_go;
  always_ff @(posedge clk)
    if (!reset_n) state <= IDLE;
    else state <= next;
  always_comb begin
    next = state;
    case (state)
      IDLE:     next = dl_go ? (nv_busy ? DL_STALL : DL_WRITE) : ul_go ? (nv_busy ? UL_STALL : UL_ADDR) : IDLE;
      DL_STALL: next = !dl_act ? IDLE : nv_busy ? DL_STALL : DL_WRITE;
      DL_WRITE: next = IDLE;
      UL_STALL: next = !ul_act ? IDLE : nv_busy ? UL_STALL : UL_ADDR;
      UL_ADDR:  next = UL_DATA;
      UL_DATA:  next = IDLE;
      default:  next = IDLE;
    endcase
  end
  // A write issued straight from IDLE never stalls the host; one released from DL_STALL keeps wait through the write.
  always_comb begin
    wait_n = next != IDLE && !(state == IDLE && next == DL_WRITE);
    sel_n  = next inside {DL_WRITE, UL_ADDR, UL_DATA};
    we_n   = next == DL_WRITE;
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ioctl_wait <= 1'b0;
      ioctl_din  <= 8'h00;
      sh_sel     <= 1'b0;
      sh_we      <= 1'b0;
      sh_addr    <= '0;
      sh_din     <= 8'h00;
      nv_dirty   <= 1'b0;
      dl_q       <= 1'b0;
      ul_q       <= 1'b0;
    end else begin
      ioctl_wait <= wait_n;
      sh_sel     <= sel_n;
      sh_we      <= we_n;
      dl_q       <= dl_act;
      ul_q       <= ul_act;
      if (dl_go || ul_go) sh_addr <= ioctl_addr[AW-1:0];
      if (dl_go) sh_din <= ioctl_dout;
      if (state == UL_DATA) ioctl_din <= sh_dout;
      else if (ul_oob) ioctl_din <= 8'hFF;
      nv_dirty <= store_done || (nv_dirty && !(dl_q && !dl_act) && !(ul_q && !ul_act));
    end
  end
endmodule

// File: tb/tb_nvram_ioctl_bridge.sv
// tb_nvram_ioctl_bridge: table vectors, directed corner sequences and random transactions against a transaction-level model.
module tb_nvram_ioctl_bridge;
  logic clk = 0, reset_n = 0;
  logic [7:0] ioctl_index = 0, ioctl_dout = 0, ioctl_din, sh_din, sh_dout, sh_addr;
  logic ioctl_download = 0, ioctl_upload = 0, ioctl_wr = 0, ioctl_rd = 0, nv_busy = 0, store_done = 0;
  logic [15:0] ioctl_addr = 0;
  logic ioctl_wait, sh_sel, sh_we, nv_dirty;
  logic preload = 1;
  logic [7:0] mem [256];
  logic [7:0] exp_mem [256];
  int compared = 0, mismatched = 0;

  always #5 clk = ~clk;

  nvram_ioctl_bridge dut (
    .clk(clk), .reset_n(reset_n), .ioctl_index(ioctl_index), .ioctl_download(ioctl_download),
    .ioctl_upload(ioctl_upload), .ioctl_wr(ioctl_wr), .ioctl_rd(ioctl_rd), .ioctl_addr(ioctl_addr),
    .ioctl_dout(ioctl_dout), .ioctl_din(ioctl_din), .ioctl_wait(ioctl_wait), .nv_busy(nv_busy),
    .store_done(store_done), .sh_sel(sh_sel), .sh_addr(sh_addr), .sh_we(sh_we), .sh_din(sh_din),
    .sh_dout(sh_dout), .nv_dirty(nv_dirty)
  );

  // Shadow array second port: synchronous write, one-cycle registered read.
  always @(posedge clk) begin
    if (preload) for (int i = 0; i < 256; i++) mem[i] <= ~8'(i);
    else if (sh_sel && sh_we) mem[sh_addr] <= sh_din;
    sh_dout <= mem[sh_addr];
  end

  typedef struct {
    bit dl; logic [7:0] idx; logic [15:0] addr; logic [7:0] data; int busy;
    int e_wait; int e_we; int e_at; int e_sel; bit keep; logic [7:0] e_din;
  } vec_t;
  vec_t tbl [9];

  task automatic step;
    @(posedge clk); #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One strobe, busy held for cycles 0..b-1, then observe a fixed window.
  task automatic xfer(input bit dl, input logic [7:0] idx, input logic [15:0] a, input logic [7:0] d, input int b,
                      output int wc, output int wec, output int weat, output int selc,
                      output logic [7:0] wa, output logic [7:0] wd, output logic [7:0] dn);
    wc = 0; wec = 0; weat = 0; selc = 0; wa = 0; wd = 0;
    ioctl_index = idx; ioctl_download = dl; ioctl_upload = !dl; ioctl_addr = a; ioctl_dout = d;
    ioctl_wr = dl; ioctl_rd = !dl; nv_busy = b > 0;
    for (int c = 1; c <= b + 8; c++) begin
      step();
      ioctl_wr = 0; ioctl_rd = 0; nv_busy = c < b;
      if (ioctl_wait) wc++;
      if (sh_sel) selc++;
      if (sh_we) begin wec++; weat = c; wa = sh_addr; wd = sh_din; end
    end
    dn = ioctl_din;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_wait"}, ioctl_wait, 0);
    chk({tag, "_din"}, ioctl_din, 0);
    chk({tag, "_sel"}, sh_sel, 0);
    chk({tag, "_we"}, sh_we, 0);
    chk({tag, "_addr"}, sh_addr, 0);
    chk({tag, "_shdin"}, sh_din, 0);
    chk({tag, "_dirty"}, nv_dirty, 0);
  endtask

  initial begin
    int wc, wec, weat, selc, cnt, b, e_wait, e_at;
    logic [7:0] wa, wd, dn, prev, idx, d;
    logic [15:0] a;
    bit dl, act, inr, e_we;
    tbl[0] = '{0, 8'd4, 16'h003C, 8'h00, 0, 2, 0, 0, 2, 0, 8'hC3};
    tbl[1] = '{0, 8'd4, 16'h0100, 8'h00, 0, 0, 0, 0, 0, 0, 8'hFF};
    tbl[2] = '{1, 8'd4, 16'h0010, 8'hC3, 20, 21, 1, 21, 1, 1, 8'h00};
    tbl[3] = '{0, 8'd4, 16'h0010, 8'h00, 3, 5, 0, 0, 2, 0, 8'hC3};
    tbl[4] = '{1, 8'd0, 16'h0020, 8'h55, 0, 0, 0, 0, 0, 1, 8'h00};
    tbl[5] = '{0, 8'd0, 16'h0020, 8'h00, 0, 0, 0, 0, 0, 1, 8'h00};
    tbl[6] = '{1, 8'd4, 16'h01FF, 8'h77, 0, 0, 0, 0, 0, 1, 8'h00};
    tbl[7] = '{0, 8'd4, 16'h00FF, 8'h00, 0, 2, 0, 0, 2, 0, 8'h00};
    tbl[8] = '{0, 8'd4, 16'h0020, 8'h00, 2, 4, 0, 0, 2, 0, 8'hDF};
    for (int i = 0; i < 256; i++) exp_mem[i] = ~8'(i);
    step(); step();
    chk_reset("reset");
    preload = 0; reset_n = 1;
    step();
    foreach (tbl[k]) begin
      prev = ioctl_din;
      xfer(tbl[k].dl, tbl[k].idx, tbl[k].addr, tbl[k].data, tbl[k].busy, wc, wec, weat, selc, wa, wd, dn);
      chk($sformatf("tbl%0d_wait", k), wc, tbl[k].e_wait);
      chk($sformatf("tbl%0d_we", k), wec, tbl[k].e_we);
      chk($sformatf("tbl%0d_we_at", k), weat, tbl[k].e_at);
      chk($sformatf("tbl%0d_sel", k), selc, tbl[k].e_sel);
      chk($sformatf("tbl%0d_din", k), dn, tbl[k].keep ? prev : tbl[k].e_din);
      if (tbl[k].e_we != 0) begin
        chk($sformatf("tbl%0d_wdata", k), {wa, wd}, {tbl[k].addr[7:0], tbl[k].data});
        exp_mem[tbl[k].addr[7:0]] = tbl[k].data;
      end
    end
    for (int i = 0; i < 256; i++) begin
      xfer(1, 8'd4, 16'(i), 8'(i) ^ 8'h5A, 0, wc, wec, weat, selc, wa, wd, dn);
      chk($sformatf("dl_full_%0d", i), {8'(wec), 8'(weat), wa, wd, 8'(wc)}, {8'd1, 8'd1, 8'(i), 8'(i) ^ 8'h5A, 8'd0});
      exp_mem[i] = 8'(i) ^ 8'h5A;
    end
    ioctl_download = 0;
    step(); step();
    chk("dl_end_dirty", nv_dirty, 0);
    store_done = 1;
    step();
    store_done = 0;
    chk("store_sets_dirty", nv_dirty, 1);
    for (int i = 0; i < 256; i++) begin
      xfer(0, 8'd4, 16'(i), 8'h00, 0, wc, wec, weat, selc, wa, wd, dn);
      chk($sformatf("ul_full_%0d", i), {dn, 8'(wc)}, {exp_mem[i], 8'd2});
    end
    chk("ul_active_dirty", nv_dirty, 1);
    ioctl_upload = 0;
    step();
    chk("ul_fall_clears", nv_dirty, 0);
    store_done = 1;
    step();
    store_done = 0; ioctl_upload = 1;
    step();
    ioctl_upload = 0; store_done = 1;
    step();
    store_done = 0;
    chk("store_wins_clear", nv_dirty, 1);
    ioctl_download = 1;
    step();
    ioctl_download = 0;
    step();
    chk("dl_fall_clears", nv_dirty, 0);
    // Abort a stalled download: the write must never reach the shadow array.
    ioctl_index = 8'd4; ioctl_download = 1; ioctl_wr = 1; ioctl_addr = 16'h0040; ioctl_dout = 8'h99; nv_busy = 1;
    step();
    ioctl_wr = 0;
    step();
    chk("abort_stall_wait", ioctl_wait, 1);
    ioctl_download = 0;
    step();
    chk("abort_wait_drop", ioctl_wait, 0);
    nv_busy = 0; cnt = 0;
    for (int c = 0; c < 6; c++) begin step(); if (sh_we || sh_sel) cnt++; end
    chk("abort_no_write", cnt, 0);
    xfer(0, 8'd4, 16'h0040, 8'h00, 0, wc, wec, weat, selc, wa, wd, dn);
    chk("abort_mem_kept", dn, exp_mem[8'h40]);
    // Reset in the middle of an upload.
    ioctl_upload = 1; ioctl_rd = 1; ioctl_addr = 16'h003C;
    step();
    ioctl_rd = 0;
    chk("ul_addr_sel", sh_sel, 1);
    reset_n = 0;
    step();
    chk_reset("midreset");
    reset_n = 1; cnt = 0;
    for (int c = 0; c < 5; c++) begin step(); if (sh_sel || ioctl_wait) cnt++; end
    chk("midreset_quiet", cnt, 0);
    ioctl_upload = 0;
    step();
    for (int n = 0; n < 60; n++) begin
      dl = 1'($urandom);
      idx = ($urandom % 4 == 0) ? 8'd0 : 8'd4;
      a = 16'($urandom_range(0, 299));
      d = 8'($urandom);
      b = $urandom_range(0, 4);
      prev = ioctl_din;
      xfer(dl, idx, a, d, b, wc, wec, weat, selc, wa, wd, dn);
      act = idx == 8'd4; inr = a < 256;
      e_we = act && dl && inr;
      e_wait = !(act && inr) ? 0 : dl ? (b > 0 ? b + 1 : 0) : b + 2;
      e_at = e_we ? b + 1 : 0;
      chk($sformatf("rnd%0d_wait", n), wc, e_wait);
      chk($sformatf("rnd%0d_we", n), {8'(wec), 8'(weat)}, {8'(e_we), 8'(e_at)});
      chk($sformatf("rnd%0d_din", n), dn, (act && !dl) ? (inr ? exp_mem[a[7:0]] : 8'hFF) : prev);
      if (e_we) begin
        chk($sformatf("rnd%0d_wdata", n), {wa, wd}, {a[7:0], d});
        exp_mem[a[7:0]] = d;
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
